// File: rtl/prog_mem_loader.sv
// prog_mem_loader
// Instruction RAM plus byte-stream loader for the picoMIPS core.
// A program image arrives one byte at a time, most significant byte of each
// word first. The bytes are packed into words and written to the RAM. The PC
// is held with `halt` until the image is complete. After that, every PC
// address gets a registered instruction word one cycle later.
//
// Optional feature: define PROG_MEM_CHECKSUM_EN to expect one trailing
// checksum byte. That byte is the XOR of all data bytes and carries
// `load_last`. The default build has no checksum logic.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high
//   addr         instruction address from the PC
//   instr        registered instruction word for the sampled addr
//   instr_valid  instr belongs to the current run
//   halt         freezes the PC (high in every state except RUN)
//   load_start   one-cycle pulse that begins or restarts a load
//   load_byte    image byte
//   load_valid   load_byte is present
//   load_last    final image byte (the checksum byte when enabled)
//   load_ready   loader accepts a byte this cycle
//   load_error   sticky overflow / checksum failure flag
//
// States
//   state  | meaning
//   S_HALT | idle, PC frozen, waiting for load_start
//   S_LOAD | accepting image bytes and writing words
//   S_WARM | one cycle that primes instr with mem[addr] for the frozen PC
//   S_RUN  | PC free, instr <= mem[addr] every cycle
module prog_mem_loader #(
  parameter int AddrSz  = 6,
  parameter int InstrSz = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [AddrSz-1:0]  addr,
  output logic [InstrSz-1:0] instr,
  output logic               instr_valid,
  output logic               halt,
  input  logic               load_start,
  input  logic [7:0]         load_byte,
  input  logic               load_valid,
  input  logic               load_last,
  output logic               load_ready,
  output logic               load_error
);

  localparam int BytesPerInstr = InstrSz / 8;
  localparam int CntW          = (BytesPerInstr > 1) ? $clog2(BytesPerInstr) : 1;
  localparam int Depth         = 1 << AddrSz;
  localparam logic [CntW-1:0] LastSlot = CntW'(BytesPerInstr - 1);

  typedef enum logic [1:0] {
    S_HALT = 2'd0,
    S_LOAD = 2'd1,
    S_WARM = 2'd2,
    S_RUN  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [AddrSz-1:0]  wr_addr_q, wr_addr_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [InstrSz-1:0] asm_q, asm_d;
  logic               full_q, full_d;
  logic               err_q, err_d;
  logic [InstrSz-1:0] instr_q, instr_d;
  logic               halt_q, valid_q, ready_q;
`ifdef PROG_MEM_CHECKSUM_EN
  logic [7:0]         csum_q, csum_d;
`endif

  logic               mem_we;
  logic [AddrSz-1:0]  mem_waddr;
  logic [InstrSz-1:0] mem_wdata;
  logic [InstrSz-1:0] mem_q [Depth];

  logic               byte_acc;
  logic [InstrSz-1:0] asm_shift;
  logic               wr_req;
  logic [InstrSz-1:0] wr_word;

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    cnt_d     = cnt_q;
    asm_d     = asm_q;
    full_d    = full_q;
    err_d     = err_q;
`ifdef PROG_MEM_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    mem_we    = 1'b0;
    mem_waddr = wr_addr_q;
    mem_wdata = '0;
    wr_req    = 1'b0;
    wr_word   = '0;
    byte_acc  = load_valid && ready_q;
    // Assembler contents with the incoming byte appended in the low byte.
    asm_shift = (asm_q << 8) | InstrSz'(load_byte);

    instr_d = instr_q;
    if (state_q == S_WARM || state_q == S_RUN) begin
      instr_d = mem_q[addr];
    end

    if (load_start) begin
      // A restart wins over any byte presented in the same cycle.
      state_d   = S_LOAD;
      wr_addr_d = '0;
      cnt_d     = '0;
      asm_d     = '0;
      full_d    = 1'b0;
      err_d     = 1'b0;
`ifdef PROG_MEM_CHECKSUM_EN
      csum_d    = '0;
`endif
    end else begin
      unique case (state_q)
        S_HALT: ;
        S_LOAD: begin
          if (byte_acc) begin
`ifdef PROG_MEM_CHECKSUM_EN
            if (!load_last) begin
              csum_d  = csum_q ^ load_byte;
              wr_req  = (cnt_q == LastSlot);
              wr_word = asm_shift;
            end else begin
              // The checksum byte flushes any partial word, zero-padded
              // in the low bytes.
              wr_req  = (cnt_q != '0);
              wr_word = asm_q << (8 * (BytesPerInstr - int'(cnt_q)));
            end
`else
            // A full word needs no shift. A final partial word is
            // left-aligned, so its missing low bytes are zero.
            wr_req  = (cnt_q == LastSlot) || load_last;
            wr_word = asm_shift << (8 * (BytesPerInstr - 1 - int'(cnt_q)));
`endif
            if (cnt_q == LastSlot || load_last) begin
              cnt_d = '0;
              asm_d = '0;
            end else begin
              cnt_d = cnt_q + CntW'(1);
              asm_d = asm_shift;
            end

            // full_q is set once the top address has been written.
            // After that, words are discarded instead of wrapping to 0.
            if (wr_req) begin
              if (full_q) begin
                err_d = 1'b1;
              end else begin
                mem_we    = 1'b1;
                mem_wdata = wr_word;
                wr_addr_d = wr_addr_q + AddrSz'(1);
                if (&wr_addr_q) begin
                  full_d = 1'b1;
                end
              end
            end

            if (load_last) begin
`ifdef PROG_MEM_CHECKSUM_EN
              if (load_byte != csum_q) begin
                err_d = 1'b1;
              end
`endif
              state_d = err_d ? S_HALT : S_WARM;
            end
          end
        end
        S_WARM:  state_d = S_RUN;
        S_RUN:   ;
        default: state_d = S_HALT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_HALT;
      wr_addr_q <= '0;
      cnt_q     <= '0;
      asm_q     <= '0;
      full_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef PROG_MEM_CHECKSUM_EN
      csum_q    <= '0;
`endif
      instr_q   <= '0;
      halt_q    <= 1'b1;
      valid_q   <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      cnt_q     <= cnt_d;
      asm_q     <= asm_d;
      full_q    <= full_d;
      err_q     <= err_d;
`ifdef PROG_MEM_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
      instr_q   <= instr_d;
      // Outputs are decoded from the next state so they change on the
      // same edge as the state itself.
      halt_q    <= (state_d != S_RUN);
      valid_q   <= (state_d == S_RUN);
      ready_q   <= (state_d == S_LOAD);
    end
  end

  // Memory contents survive reset. A write presented in a reset cycle is
  // dropped.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign halt        = halt_q;
  assign load_ready  = ready_q;
  assign load_error  = err_q;

endmodule

// File: tb/tb_prog_mem_loader.sv
module tb_prog_mem_loader;
  localparam int AddrSz  = 6;
  localparam int InstrSz = 24;
`ifdef PROG_MEM_CHECKSUM_EN
  localparam bit CsumMode = 1'b1;
`else
  localparam bit CsumMode = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic [AddrSz-1:0]  addr;
  logic [InstrSz-1:0] instr;
  logic               instr_valid;
  logic               halt;
  logic               load_start;
  logic [7:0]         load_byte;
  logic               load_valid;
  logic               load_last;
  logic               load_ready;
  logic               load_error;

  prog_mem_loader #(.AddrSz(AddrSz), .InstrSz(InstrSz)) dut (
    .clk         (clk),
    .reset       (reset),
    .addr        (addr),
    .instr       (instr),
    .instr_valid (instr_valid),
    .halt        (halt),
    .load_start  (load_start),
    .load_byte   (load_byte),
    .load_valid  (load_valid),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .load_error  (load_error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [InstrSz-1:0] exp_q [$];
  logic [InstrSz-1:0] mon_exp;
  logic [7:0]         xacc;

  // Monitor: every presented instruction is matched against the scoreboard.
  always @(negedge clk) begin
    if (instr_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL fetch_unexpected: got instr=%06h, required no valid output", instr);
      end else begin
        mon_exp = exp_q.pop_front();
        if (instr !== mon_exp) begin
          bad++;
          $display("FAIL fetch: got instr=%06h, required %06h", instr, mon_exp);
        end
      end
    end
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [InstrSz-1:0] act, input logic [InstrSz-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %06h, required %06h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic with_byte);
    load_start = 1'b1;
    load_valid = with_byte;
    load_byte  = 8'hAA;
    load_last  = 1'b0;
    step();
    load_start = 1'b0;
    load_valid = 1'b0;
    xacc       = 8'h00;
    chk1("start_ready", load_ready, 1'b1);
    chk1("start_halt", halt, 1'b1);
    chk1("start_valid", instr_valid, 1'b0);
    chk1("start_err_clr", load_error, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int n = 0;
    while (load_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (load_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got load_ready=%b, required 1", load_ready);
    end
    load_valid = 1'b1;
    load_byte  = b;
    load_last  = last;
    if (!(last && CsumMode)) xacc ^= b;
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic send_data(input logic [7:0] b, input logic is_final);
    send_byte(b, is_final && !CsumMode);
  endtask

  task automatic end_image(input logic corrupt);
    if (CsumMode) send_byte(corrupt ? (xacc ^ 8'h01) : xacc, 1'b1);
  endtask

  task automatic fetch(input logic [AddrSz-1:0] a, input logic [InstrSz-1:0] e);
    addr = a;
    exp_q.push_back(e);
    step();
  endtask

  task automatic check_warm_then_run(input logic [AddrSz-1:0] a, input logic [InstrSz-1:0] e);
    chk1("warm_halt", halt, 1'b1);
    chk1("warm_valid", instr_valid, 1'b0);
    chk1("warm_ready", load_ready, 1'b0);
    fetch(a, e);
    chk1("run_halt", halt, 1'b0);
    chk1("run_valid", instr_valid, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; addr = '0; load_start = 1'b0; load_byte = 8'h00;
    load_valid = 1'b0; load_last = 1'b0; xacc = 8'h00;
    step(); step();
    reset = 1'b0;

    // Idle after reset; bytes in HALT are ignored.
    load_valid = 1'b1; load_byte = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      step();
      chk1("rst_halt", halt, 1'b1);
      chk1("rst_valid", instr_valid, 1'b0);
      chkw("rst_instr", instr, 24'h000000);
      chk1("rst_ready", load_ready, 1'b0);
      chk1("rst_err", load_error, 1'b0);
    end
    load_valid = 1'b0;

    // Two full words.
    start_load(1'b0);
    send_data(8'h12, 1'b0); send_data(8'h34, 1'b0); send_data(8'h56, 1'b0);
    send_data(8'hAB, 1'b0); send_data(8'hCD, 1'b0); send_data(8'hEF, 1'b1);
    end_image(1'b0);
    check_warm_then_run(6'd0, 24'h123456);
    fetch(6'd1, 24'hABCDEF);

    // Restart from RUN; partial final word is zero-padded.
    start_load(1'b0);
    send_data(8'h11, 1'b0); send_data(8'h22, 1'b0); send_data(8'h33, 1'b0);
    send_data(8'h44, 1'b1);
    end_image(1'b0);
    check_warm_then_run(6'd1, 24'h440000);
    fetch(6'd0, 24'h112233);
    fetch(6'd1, 24'h440000);

    // Restart together with a byte: the byte is dropped.
    start_load(1'b1);
    send_data(8'hFF, 1'b0); send_data(8'hFF, 1'b0); send_data(8'hFF, 1'b1);
    end_image(1'b0);
    check_warm_then_run(6'd0, 24'hFFFFFF);
    fetch(6'd1, 24'h440000);

    // Reset mid-load keeps words already written.
    start_load(1'b0);
    send_data(8'h5A, 1'b0); send_data(8'h5B, 1'b0); send_data(8'h5C, 1'b0);
    send_data(8'h60, 1'b0); send_data(8'h61, 1'b0); send_data(8'h62, 1'b0);
    send_data(8'h77, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk1("midrst_halt", halt, 1'b1);
    chk1("midrst_ready", load_ready, 1'b0);
    chk1("midrst_valid", instr_valid, 1'b0);
    start_load(1'b0);
    send_data(8'h9A, 1'b0); send_data(8'hBC, 1'b0); send_data(8'hDE, 1'b1);
    end_image(1'b0);
    check_warm_then_run(6'd1, 24'h606162);
    fetch(6'd0, 24'h9ABCDE);

    // Overflow: 65 words into a 64-word memory.
    start_load(1'b0);
    for (int i = 0; i < 64; i++) begin
      send_data(8'(i), 1'b0);
      send_data(~8'(i), 1'b0);
      send_data(8'h3C, 1'b0);
    end
    send_data(8'h40, 1'b0);
    send_data(8'hBF, 1'b0);
    chk1("ovf_err_before", load_error, 1'b0);
    send_data(8'h3C, 1'b0);
    chk1("ovf_err_set", load_error, 1'b1);
    chk1("ovf_ready", load_ready, 1'b1);
    chk1("ovf_halt", halt, 1'b1);
    send_data(8'hEE, 1'b1);
    end_image(1'b0);
    chk1("ovf_end_ready", load_ready, 1'b0);
    chk1("ovf_end_halt", halt, 1'b1);
    chk1("ovf_end_err", load_error, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk1("ovf_idle_halt", halt, 1'b1);
      chk1("ovf_idle_valid", instr_valid, 1'b0);
      chk1("ovf_idle_err", load_error, 1'b1);
    end
    start_load(1'b0);
    send_data(8'h13, 1'b0); send_data(8'h57, 1'b0); send_data(8'h9B, 1'b1);
    end_image(1'b0);
    check_warm_then_run(6'd0, 24'h13579B);
    fetch(6'd63, 24'h3FC03C);
    fetch(6'd2, 24'h02FD3C);

`ifdef PROG_MEM_CHECKSUM_EN
    // Checksum good (0x07) then bad (0x06).
    start_load(1'b0);
    send_data(8'h01, 1'b0); send_data(8'h02, 1'b0); send_data(8'h04, 1'b1);
    end_image(1'b0);
    check_warm_then_run(6'd0, 24'h010204);
    start_load(1'b0);
    send_data(8'h01, 1'b0); send_data(8'h02, 1'b0); send_data(8'h04, 1'b1);
    end_image(1'b1);
    chk1("csum_bad_err", load_error, 1'b1);
    chk1("csum_bad_ready", load_ready, 1'b0);
    step();
    chk1("csum_bad_halt", halt, 1'b1);
    chk1("csum_bad_valid", instr_valid, 1'b0);
`endif

    reset = 1'b1;
    step();
    reset = 1'b0;
    step(); step();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/prog_mem_loader.md
# prog_mem_loader

Program memory and loader for the picoMIPS core. It sits at the far end of the program counter's instruction-address interface. It accepts a byte-stream program image, writes it into an internal instruction RAM, and holds the PC with `halt` while loading. Once loading is complete, it answers each PC address with a registered instruction word.

## Interface
- `AddrSz`, default 6: instruction address width; memory depth is 2^AddrSz words.
- `InstrSz`, default 24: instruction width in bits; must be a multiple of 8. BytesPerInstr = InstrSz/8.
- `clk`  input  1  clock; all state changes on the rising edge.
- `reset`  input  1  reset; synchronous, active-high.
- `addr`  input  AddrSz  instruction address from the PC.
- `instr`  output  InstrSz  instruction word for the PC address.
- `instr_valid`  output  1  `instr` is valid for the current run.
- `halt`  output  1  freezes the PC; high in every state except RUN.
- `load_start`  input  1  one-cycle pulse that begins or restarts a program load.
- `load_byte`  input  8  image byte; the most significant byte of each word comes first.
- `load_valid`  input  1  `load_byte` is present.
- `load_last`  input  1  qualifies the final image byte (the data byte, or the checksum byte when the checksum is enabled).
- `load_ready`  output  1  the loader accepts a byte this cycle.
- `load_error`  output  1  sticky flag for overflow or checksum failure; cleared by `load_start` or `reset`.

## Operation
- States: HALT, LOAD, WARM, RUN. On reset the block enters HALT with `halt`=1, `instr`=0, `instr_valid`=0, `load_ready`=0 and `load_error`=0. Memory contents are not reset.
- HALT: waits for `load_start`. `load_valid` is ignored in this state.
- `load_start` in any state moves to LOAD on the next edge and clears the write address, the byte counter, the checksum and `load_error`.
- LOAD: `load_ready`=1. A byte is accepted when `load_valid`&&`load_ready`.
  - Each accepted byte is shifted into the word assembler.
  - On the BytesPerInstr-th byte, the word {assembler, `load_byte`} is written to mem[wr_addr] in the same cycle, and wr_addr increments.
- Final byte (`load_last` set on a data byte):
  - If the word is partial, the remaining low bytes are zero-padded and the word is written.
  - The state then moves to WARM, or goes through the checksum step when that feature is enabled.
- Overflow: if the image would write a word after wr_addr has already passed 2^AddrSz-1:
  - `load_error` is set.
  - Further bytes are accepted and discarded, with no wrap to address 0.
  - On `load_last` the state returns to HALT, not WARM.
- WARM lasts one cycle with `halt`=1. During it, `instr` <= mem[`addr`], so the first fetch is primed.
- RUN: `halt`=0, `instr_valid`=1, and `instr` <= mem[`addr`] every cycle.
- `load_start` in RUN: the next edge enters LOAD, so `halt`=1 and `instr_valid`=0 from that edge.
- `load_start` and a byte in the same cycle: the restart wins and the byte is dropped.
- Reset in mid-load returns to HALT. Words already written stay in memory.

## Timing
- Fetch latency is 1 cycle: `addr` sampled at edge N appears on `instr` after edge N.
- `halt` deasserts on the edge that enters RUN; the PC advances from the following edge.
- In WARM, `instr` holds mem[`addr`] for the frozen PC value, so the first RUN instruction is correct without a bubble.
- Word write occurs on the same edge that accepts the final byte of the word. A write and a read of the same address never coincide, because reads occur only in WARM and RUN.
- From the `load_last` acceptance edge, WARM lasts 1 cycle and RUN is entered on the second edge after acceptance.

## Configuration
- `PROG_MEM_CHECKSUM_EN` defined:
  - After the last data byte (`load_valid` high, `load_last` low), the loader expects one checksum byte with `load_last`=1.
  - The checksum equals the XOR of all image data bytes.
  - On a match the state moves to WARM. On a mismatch `load_error`=1 and the state returns to HALT.
- `PROG_MEM_CHECKSUM_EN` undefined:
  - No checksum logic.
  - The byte carrying `load_last` is the final data byte, and the state moves directly to WARM (or to HALT on overflow).

## Test plan
- Reset, then idle 5 cycles: `halt`=1, `instr_valid`=0, `instr`=0, `load_ready`=0 throughout.
- Load bytes 0x12,0x34,0x56,0xAB,0xCD,0xEF (last flagged), then present `addr`=0 and `addr`=1 on consecutive cycles: mem[0]=0x123456, mem[1]=0xABCDEF; `halt` falls 2 cycles after the last byte; `instr` reads 0x123456 then 0xABCDEF with 1-cycle latency.
- Load 4 bytes 0x11,0x22,0x33,0x44 (last flagged): mem[1]=0x440000 (zero-padded).
- Load 65 words with `AddrSz`=6: `load_error`=1 at word 64, mem[0] unchanged, state returns to HALT, `halt` stays 1.
- In RUN, pulse `load_start`: `halt`=1 and `instr_valid`=0 on the next edge; a new 1-word load of 0xFFFFFF then gives mem[0]=0xFFFFFF.
- With `PROG_MEM_CHECKSUM_EN`: image 0x01,0x02,0x04 plus checksum 0x07 reaches RUN; the same image with checksum 0x06 sets `load_error`=1 and returns to HALT.
